// File: rtl/sync_pkg.sv
// Shared widths and output-FSM encoding for the sync word packer.
// Imported by the packer top level and its queue.
package sync_pkg;

    localparam int WORD_W         = 32;
    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = 4;
    localparam int CNT_W          = 2;

    typedef enum logic {
        EMIT = 1'b0,
        WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Wrap-around word queue with a count register.
// A push into a full queue lands only when a pop happens on the same edge.
module sync_fifo
    import sync_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [AW-1:0]     rd_q;
    logic [AW-1:0]     wr_q;
    logic [AW:0]       cnt_q;
    logic              do_push;
    logic              do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage needs no reset: the count alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_q] <= wdata;
    end

endmodule

// File: rtl/sync_word_packer.sv
// Packs bytes little-endian into 32-bit words and emits them as
// single-cycle srdyo pulses spaced by at least GAP idle cycles.
module sync_word_packer
    import sync_pkg::*;
#(
    parameter int GAP   = 1,
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              GlobalReset,
    input  logic [BYTE_W-1:0] din,
    input  logic              dvalid,
    input  logic              flush,
    output logic [WORD_W-1:0] sync_o,
    output logic              srdyo,
    output logic [CNT_W-1:0]  byte_cnt,
    output logic              ovf
);

    logic [WORD_W-1:0] part_q;
    logic [WORD_W-1:0] merged;
    logic [WORD_W-1:0] head;
    logic [CNT_W:0]    cnt_nxt;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    state_t            state_q;
    state_t            state_d;
    logic [1:0]        wait_q;
    logic [1:0]        wait_d;

    // The same-cycle byte is merged before a flush closes the word.
    always_comb begin
        merged = part_q;
        if (dvalid) merged[{byte_cnt, 3'b000} +: BYTE_W] = din;
        cnt_nxt = {1'b0, byte_cnt} + {{CNT_W{1'b0}}, dvalid};
        push    = (cnt_nxt == (CNT_W+1)'(BYTES_PER_WORD))
                | (flush & (cnt_nxt != '0));
    end

    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            part_q   <= '0;
            byte_cnt <= '0;
        end else if (push) begin
            part_q   <= '0;
            byte_cnt <= '0;
        end else if (dvalid) begin
            part_q   <= merged;
            byte_cnt <= cnt_nxt[CNT_W-1:0];
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (GlobalReset),
        .push  (push),
        .pop   (pop),
        .wdata (merged),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            ovf <= 1'b0;
        end else if (push & full & ~pop) begin
            ovf <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        pop     = 1'b0;
        unique case (state_q)
            EMIT: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = WAIT;
                    wait_d  = '0;
                end
            end
            WAIT: begin
                if (wait_q == 2'(GAP - 1)) state_d = EMIT;
                else                       wait_d  = wait_q + 2'd1;
            end
        endcase
    end

    // sync_o only moves on a pop so the downstream stage sees a stable word.
    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            state_q <= EMIT;
            wait_q  <= '0;
            srdyo   <= 1'b0;
            sync_o  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            srdyo   <= pop;
            if (pop) sync_o <= head;
        end
    end

endmodule

// File: tb/tb_sync_word_packer.sv
// Bench for sync_word_packer: GAP=1 and GAP=3 instances share stimulus
// and are checked every cycle against a queue-based model.
module tb_sync_word_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  din;
    logic        dvalid;
    logic        flush;
    logic [31:0] so0, so1;
    logic        sr0, sr1, ov0, ov1;
    logic [1:0]  bc0, bc1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sync_word_packer #(.GAP(1), .DEPTH(2)) u_dut0 (
        .clk(clk), .GlobalReset(rst_n), .din(din), .dvalid(dvalid),
        .flush(flush), .sync_o(so0), .srdyo(sr0), .byte_cnt(bc0), .ovf(ov0)
    );

    sync_word_packer #(.GAP(3), .DEPTH(2)) u_dut1 (
        .clk(clk), .GlobalReset(rst_n), .din(din), .dvalid(dvalid),
        .flush(flush), .sync_o(so1), .srdyo(sr1), .byte_cnt(bc1), .ovf(ov1)
    );

    int          gapv[2] = '{1, 3};
    logic [7:0]  mb[2][$];
    logic [31:0] mq[2][$];
    int          last_e[2];
    int          edge_n = 0;
    logic [31:0] e_so[2];
    logic        e_sr[2];
    logic        e_ov[2];
    logic [31:0] mw;
    logic [31:0] obs0[$];
    logic [31:0] obs1[$];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", n, act, exp);
        end
    endtask

    // Model: per edge, emit the queue head if GAP edges have passed since the
    // last pulse, then gather the byte and close a word on 4 bytes or flush.
    always @(posedge clk) begin
        edge_n++;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                mb[i].delete();
                mq[i].delete();
                last_e[i] = -100;
                e_so[i]   = '0;
                e_sr[i]   = 1'b0;
                e_ov[i]   = 1'b0;
            end else begin
                e_sr[i] = 1'b0;
                if (mq[i].size() > 0 && edge_n - last_e[i] > gapv[i]) begin
                    e_so[i]   = mq[i].pop_front();
                    e_sr[i]   = 1'b1;
                    last_e[i] = edge_n;
                end
                if (dvalid) mb[i].push_back(din);
                if (mb[i].size() == 4 || (flush && mb[i].size() > 0)) begin
                    mw = '0;
                    for (int k = 0; k < mb[i].size(); k++) mw[8*k +: 8] = mb[i][k];
                    mb[i].delete();
                    if (mq[i].size() < 2) mq[i].push_back(mw);
                    else                  e_ov[i] = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_sync_o0", so0, 0);
            chk("rst_srdyo0", {31'b0, sr0}, 0);
            chk("rst_cnt1", {30'b0, bc1}, 0);
            chk("rst_ovf1", {31'b0, ov1}, 0);
        end else begin
            chk("sync_o0", so0, e_so[0]);
            chk("srdyo0", {31'b0, sr0}, {31'b0, e_sr[0]});
            chk("byte_cnt0", {30'b0, bc0}, mb[0].size());
            chk("ovf0", {31'b0, ov0}, {31'b0, e_ov[0]});
            chk("sync_o1", so1, e_so[1]);
            chk("srdyo1", {31'b0, sr1}, {31'b0, e_sr[1]});
            chk("byte_cnt1", {30'b0, bc1}, mb[1].size());
            chk("ovf1", {31'b0, ov1}, {31'b0, e_ov[1]});
        end
        if (sr0) obs0.push_back(so0);
        if (sr1) obs1.push_back(so1);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic cyc(input logic v, input logic [7:0] d, input logic f);
        dvalid = v;
        din    = d;
        flush  = f;
        tick();
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 8'h00, 1'b0);
    endtask

    function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
        return (q.size() > i) ? q[i] : 32'hxxxxxxxx;
    endfunction

    initial begin
        rst_n  = 1'b0;
        din    = '0;
        dvalid = 1'b0;
        flush  = 1'b0;
        tick();
        tick();
        chk("reset_sync_o", so0, 0);
        chk("reset_srdyo", {31'b0, sr1}, 0);
        rst_n = 1'b1;
        idle(2);

        cyc(1, 8'h11, 0);
        cyc(1, 8'h22, 0);
        cyc(1, 8'h33, 0);
        cyc(1, 8'h44, 0);
        chk("lat_edge_n_srdyo", {31'b0, sr0}, 0);
        chk("lat_edge_n_cnt", {30'b0, bc0}, 0);
        idle(1);
        chk("lat_edge_n1_srdyo", {31'b0, sr0}, 1);
        chk("word_11223344", so0, 32'h44332211);
        idle(1);
        chk("pulse_one_cycle", {31'b0, sr0}, 0);
        chk("sync_o_hold", so0, 32'h44332211);
        idle(6);

        obs0.delete();
        cyc(1, 8'hAA, 0);
        cyc(1, 8'hBB, 0);
        chk("cnt_two", {30'b0, bc0}, 2);
        cyc(0, 8'h00, 1);
        chk("cnt_after_flush", {30'b0, bc0}, 0);
        idle(6);
        chk("flush_count", obs0.size(), 1);
        chk("flush_word", at(obs0, 0), 32'h0000BBAA);

        obs0.delete();
        obs1.delete();
        cyc(1, 8'h01, 0);
        cyc(1, 8'h02, 0);
        cyc(1, 8'h03, 0);
        cyc(1, 8'h04, 1);
        idle(8);
        chk("b4flush_count", obs0.size(), 1);
        chk("b4flush_word", at(obs0, 0), 32'h04030201);
        chk("b4flush_count1", obs1.size(), 1);

        obs0.delete();
        obs1.delete();
        for (int b = 0; b < 12; b++) cyc(1, 8'(b), 0);
        idle(10);
        chk("seq_count", obs0.size(), 3);
        chk("seq_w0", at(obs0, 0), 32'h03020100);
        chk("seq_w1", at(obs0, 1), 32'h07060504);
        chk("seq_w2", at(obs0, 2), 32'h0B0A0908);
        chk("seq_ovf", {31'b0, ov0}, 0);

        obs0.delete();
        obs1.delete();
        cyc(1, 8'hA1, 1);
        cyc(1, 8'hA2, 1);
        cyc(1, 8'hA3, 1);
        cyc(1, 8'hA4, 1);
        idle(16);
        chk("drop_count", obs1.size(), 3);
        chk("drop_w0", at(obs1, 0), 32'h000000A1);
        chk("drop_w1", at(obs1, 1), 32'h000000A2);
        chk("drop_w2", at(obs1, 2), 32'h000000A3);
        chk("drop_ovf", {31'b0, ov1}, 1);
        chk("nodrop_count_gap1", obs0.size(), 4);

        cyc(1, 8'hC1, 1);
        cyc(1, 8'hC2, 1);
        cyc(1, 8'hD1, 0);
        cyc(1, 8'hD2, 0);
        dvalid = 1'b0;
        flush  = 1'b0;
        chk("pre_reset_cnt", {30'b0, bc1}, 2);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_sync_o", so1, 0);
        chk("async_rst_cnt", {30'b0, bc1}, 0);
        chk("async_rst_ovf", {31'b0, ov1}, 0);
        chk("async_rst_srdyo", {31'b0, sr0}, 0);
        tick();
        tick();
        rst_n = 1'b1;
        obs0.delete();
        obs1.delete();
        idle(8);
        chk("post_rst_quiet0", obs0.size(), 0);
        chk("post_rst_quiet1", obs1.size(), 0);
        cyc(1, 8'hE1, 0);
        cyc(1, 8'hE2, 0);
        cyc(1, 8'hE3, 0);
        cyc(1, 8'hE4, 0);
        idle(8);
        chk("post_rst_count", obs1.size(), 1);
        chk("post_rst_word", at(obs1, 0), 32'hE4E3E2E1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sync_word_packer.md
SYNC_WORD_PACKER -- requirements
Module: sync_word_packer

Interface
REQ-001 SHALL have parameter GAP, default 1: minimum idle cycles between srdyo pulses (legal range 1..3).
REQ-002 SHALL have parameter DEPTH, default 2: output queue entries (power of two, at least 2).
REQ-003 SHALL have port clk, input, 1: single clock; all state on its rising edge.
REQ-004 SHALL have port GlobalReset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port din, input, 8: byte to pack.
REQ-006 SHALL have port dvalid, input, 1: din valid this cycle; one byte accepted per cycle, no backpressure.
REQ-007 SHALL have port flush, input, 1: close the current partial word.
REQ-008 SHALL have port sync_o, output, 32: packed word, feeding the downstream delay stage's sync_i.
REQ-009 SHALL have port srdyo, output, 1: one-cycle pulse marking a new sync_o, feeding the downstream srdyi.
REQ-010 SHALL have port byte_cnt, output, 2: bytes held in the partial word.
REQ-011 SHALL have port ovf, output, 1: sticky flag set when a completed word is dropped.

Function
REQ-012 SHALL pack bytes little-endian: first accepted byte to [7:0], second to [15:8], third to [23:16], fourth to [31:24].
REQ-013 SHALL push the completed word into the queue at the edge that accepts the 4th byte, and SHALL reset byte_cnt to 0 at that edge.
REQ-014 SHALL, when flush=1 and byte_cnt>0 (after any same-cycle byte), push the partial word with unfilled bytes set to zero, and SHALL reset byte_cnt to 0.
REQ-015 SHALL, when dvalid=1 and flush=1 in the same cycle, append the byte first, then apply flush; if that byte is the 4th, exactly one word is pushed.
REQ-016 SHALL ignore flush when byte_cnt=0 and dvalid=0; no word is pushed.
REQ-017 SHALL use a two-state output FSM: EMIT and WAIT.
REQ-018 SHALL, in EMIT with the queue non-empty at a rising edge, pop the head into sync_o, drive srdyo=1 for exactly one cycle, and go to WAIT.
REQ-019 SHALL stay in WAIT for GAP cycles with srdyo=0, then return to EMIT.
REQ-020 SHALL hold sync_o unchanged from a pulse until the next pulse, because the downstream stage samples sync_i one cycle after srdyi.
REQ-021 SHALL NOT assert srdyo on two consecutive cycles.
REQ-022 SHALL give 2-cycle minimum latency: word completed at edge N gives srdyo=1 in the cycle after edge N+1 (queue empty, FSM in EMIT).
REQ-023 SHALL allow a push and a pop on the same edge; the queue count is unchanged.
REQ-024 SHALL allow a push into a full queue only if a pop occurs on the same edge; otherwise it SHALL drop the new word, keep the queued words, and set ovf=1.
REQ-025 SHALL use a wrap-around queue with read/write pointers of log2(DEPTH) bits plus a count register.

Reset
REQ-026 SHALL, while GlobalReset=0, asynchronously force sync_o=0, srdyo=0, byte_cnt=0, ovf=0, queue empty, FSM=EMIT, partial word=0.
REQ-027 SHALL, on reset asserted mid-word or mid-pulse, discard all partial and queued data; no srdyo follows reset release until new bytes complete a word.
REQ-028 SHALL deassert reset to the clk domain externally; the block does not synchronise it.

Structure
REQ-029 SHALL take word width 32, byte width 8, bytes-per-word 4 and the FSM state encoding from the shared package sync_pkg.
REQ-030 SHALL place the queue in a single sub-module, sync_fifo (push/pop/full/empty/count); packing and the FSM stay in the top level.

Verification
REQ-031 SHALL cover: dvalid=1 for 4 cycles with din=11,22,33,44 (hex) -> exactly one srdyo pulse, sync_o=44332211, latency per REQ-022.
REQ-032 SHALL cover: din=AA, BB, then flush -> sync_o=0000BBAA, byte_cnt back to 0.
REQ-033 SHALL cover: 12 consecutive bytes 00..0B (hex), GAP=1 -> 3 pulses each separated by at least 1 low cycle, words 03020100, 07060504, 0B0A0908, ovf=0.
REQ-034 SHALL cover: DEPTH=2, GAP=3, four single-byte-plus-flush words on back-to-back cycles -> the 4th word is dropped, ovf=1, and the first three words emit in order.
REQ-035 SHALL cover: reset pulsed low after 2 bytes and with 1 word queued -> all outputs 0, no srdyo after release; next 4 bytes give one correct word.
REQ-036 SHALL cover: dvalid and flush together on the 4th byte (din=01,02,03,04) -> a single word 04030201 and no extra zero word.
